// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand buffer FSM states
// and the default operand datapath width.
package cpu_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/operand_reg.sv
// WIDTH-bit storage register with load enable and sync clear.
// Ports: clk, clr_i (clear), ld_i (load), d_i (data), q_o (value).
module operand_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/operand_skid_buffer.sv
// Two-entry skid buffer between operand mux and ALU stage.
// Ports: clk, rst, in_* (upstream), out_* (downstream), count, stall_cycles.
module operand_skid_buffer
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic [15:0]      stall_cycles
);

  skid_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       count_q, count_d;
  logic [15:0]      stall_q, stall_d;

  logic             in_xfer, out_xfer;
  logic             main_ld, skid_ld;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = in_data;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_ld = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          main_ld = 1'b1;
        end else if (in_xfer) begin
          skid_ld = 1'b1;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Drain: the skid entry becomes the head.
        main_d = skid_q;
        if (out_xfer) begin
          main_ld = 1'b1;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs are registered copies of the next
  // state, so in_ready never depends on out_ready combinationally.
  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    count_d     = (state_d == ST_FULL) ? 2'd2 :
                  (state_d == ST_BUSY) ? 2'd1 : 2'd0;
    stall_d     = stall_q;
    if (state_q == ST_FULL && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
      stall_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
    end
  end

  operand_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .clr_i (rst),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  operand_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .clr_i (rst),
    .ld_i  (skid_ld),
    .d_i   (in_data),
    .q_o   (skid_q)
  );

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = main_q;
  assign count        = count_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_skid_buffer.sv
// Directed bench for operand_skid_buffer.
// Drives on negedge, samples 1ns after posedge.
module tb_operand_skid_buffer;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  count;
  logic [15:0] stall_cycles;

  int total;
  int bad;

  operand_skid_buffer #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;

    // Reset for two cycles
    step();
    step();
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_irdy",   {31'd0, in_ready},  32'd1);
    chk("rst_count",  {30'd0, count},     32'd0);
    chk("rst_stall",  {16'd0, stall_cycles}, 32'd0);
    chk("rst_odata",  {16'd0, out_data},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1..8 with out_ready high: one word per cycle
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b1);
      step();
      chk("strm_valid", {31'd0, out_valid}, 32'd1);
      chk("strm_data",  {16'd0, out_data},  32'(i));
      chk("strm_irdy",  {31'd0, in_ready},  32'd1);
    end
    drive(1'b0, 16'h0, 1'b1);
    step();
    chk("strm_drain_cnt", {30'd0, count},     32'd0);
    chk("strm_drain_ov",  {31'd0, out_valid}, 32'd0);

    // Fill both entries with downstream stalled
    drive(1'b1, 16'hAAAA, 1'b0);
    step();
    chk("fill1_cnt", {30'd0, count}, 32'd1);
    drive(1'b1, 16'h5555, 1'b0);
    step();
    chk("full_cnt",   {30'd0, count},    32'd2);
    chk("full_irdy",  {31'd0, in_ready}, 32'd0);
    chk("full_data",  {16'd0, out_data}, 32'hAAAA);
    chk("full_stall0", {16'd0, stall_cycles}, 32'd0);
    drive(1'b0, 16'h0, 1'b0);
    step();
    chk("full_hold",  {16'd0, out_data}, 32'hAAAA);
    // Offered word must be ignored while in_ready is low
    drive(1'b1, 16'h1234, 1'b0);
    step();
    chk("full_ignore", {16'd0, out_data}, 32'hAAAA);
    chk("full_cnt2",   {30'd0, count},    32'd2);
    chk("full_stall2", {16'd0, stall_cycles}, 32'd2);

    // Drain in order: AAAA leaves, then 5555
    drive(1'b0, 16'h0, 1'b1);
    step();
    chk("drain1_data", {16'd0, out_data},  32'h5555);
    chk("drain1_cnt",  {30'd0, count},     32'd1);
    chk("drain1_ov",   {31'd0, out_valid}, 32'd1);
    chk("drain_stall", {16'd0, stall_cycles}, 32'd3);
    step();
    chk("drain2_cnt", {30'd0, count},     32'd0);
    chk("drain2_ov",  {31'd0, out_valid}, 32'd0);

    // Long FULL hold: stall counter saturates
    drive(1'b1, 16'hB001, 1'b0);
    drive(1'b1, 16'hB002, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall", {16'd0, stall_cycles}, 32'hFFFF);
    chk("sat_cnt",   {30'd0, count},        32'd2);
    chk("sat_data",  {16'd0, out_data},     32'hB001);

    // Reset in FULL wins over simultaneous transfers
    drive(1'b1, 16'hC0DE, 1'b1);
    rst = 1'b1;
    step();
    chk("mrst_cnt",   {30'd0, count},        32'd0);
    chk("mrst_ov",    {31'd0, out_valid},    32'd0);
    chk("mrst_irdy",  {31'd0, in_ready},     32'd1);
    chk("mrst_data",  {16'd0, out_data},     32'd0);
    chk("mrst_stall", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_ov", {31'd0, out_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_skid_buffer.md
OPERAND_SKID_BUFFER -- requirements
Module: operand_skid_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, WIDTH, the operand from the upstream 16-bit 2:1 mux output.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-007 The block SHALL have port out_data, output, WIDTH, the operand presented to the downstream ALU stage.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning downstream consumes out_data this cycle.
REQ-010 The block SHALL have port count, output, 2, giving the number of held operands (0..2).
REQ-011 The block SHALL have port stall_cycles, output, 16, a saturating count of cycles spent in state FULL.

Function
REQ-012 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-013 The block SHALL hold two storage registers, main and skid, and track them with FSM states EMPTY, BUSY and FULL.
REQ-014 in_ready SHALL be driven directly from a register: high in EMPTY and BUSY, low in FULL, with no combinational path from out_ready.
REQ-015 out_valid SHALL be high in BUSY and FULL; out_data SHALL equal the main register.
REQ-016 In EMPTY, an input transfer SHALL load main and go to BUSY; otherwise the state SHALL stay EMPTY.
REQ-017 In BUSY, input and output transfers together SHALL load main with in_data and stay BUSY.
REQ-018 In BUSY, an input transfer alone SHALL load skid and go to FULL.
REQ-019 In BUSY, an output transfer alone SHALL go to EMPTY.
REQ-020 In BUSY, with no transfer, main SHALL be held and the state SHALL stay BUSY.
REQ-021 In FULL, an output transfer SHALL copy skid into main and go to BUSY; otherwise all registers SHALL hold.
REQ-022 Latency SHALL be 1 cycle: data accepted at edge N SHALL be on out_data after edge N.
REQ-023 Sustained throughput SHALL be one transfer per cycle while out_ready is held high.
REQ-024 Operands SHALL leave in acceptance order, with no loss and no duplication.
REQ-025 count SHALL be 0, 1 or 2 in EMPTY, BUSY or FULL respectively.
REQ-026 stall_cycles SHALL increment once per cycle in FULL and saturate at 16'hFFFF.
REQ-027 When in_ready is low, in_data and in_valid SHALL be ignored.
REQ-028 out_data SHALL remain stable while out_valid is high and out_ready is low.

Reset
REQ-029 When rst is high at a rising edge, the state SHALL become EMPTY and in_ready, count and stall_cycles SHALL reset to 1, 0 and 0.
REQ-030 Reset SHALL set out_valid to 0; main and skid SHALL be cleared to 0.
REQ-031 Reset SHALL take priority over any simultaneous transfer, and held operands SHALL be discarded when rst is asserted mid-operation.

Structure
REQ-032 State encodings (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and the default WIDTH SHALL reside in shared package cpu_pkg.
REQ-033 A single sub-module, operand_reg (WIDTH-bit register with load enable and synchronous clear), SHALL be instantiated twice, for main and skid.

Verification
REQ-034 The bench SHALL apply rst for 2 cycles and check out_valid=0, in_ready=1, count=0, stall_cycles=0.
REQ-035 The bench SHALL stream 16'h0001..16'h0008 with out_ready=1 and check eight outputs in order, one per cycle, after 1-cycle latency.
REQ-036 With out_ready=0, the bench SHALL send 16'hAAAA then 16'h5555, then check count=2, in_ready=0 and out_data=16'hAAAA stable.
REQ-037 From that FULL state, the bench SHALL raise out_ready for 2 cycles and check AAAA then 5555 in order, with count ending at 0.
REQ-038 The bench SHALL hold FULL for 70000 cycles and check that stall_cycles saturates at 16'hFFFF.
REQ-039 The bench SHALL assert rst while in FULL and check that the state becomes EMPTY and neither held word appears on the output.
